// File: rtl/binary_frame_reader.sv
// Frame reader for the 1-bit filtered QR image held in BRAM_one.
// Walks the image in row-major order and streams one tagged pixel per beat
// over valid/ready. A small credit-limited FIFO hides the BRAM read latency,
// so downstream stalls never lose or repeat a pixel.
module binary_frame_reader #(
   parameter int WIDTH        = 480,
   parameter int HEIGHT       = 480,
   parameter int BRAM_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_read,
   output logic [18:0] bram_address,
   input  logic        bram_data,
   output logic        pixel_data,
   output logic [8:0]  pixel_x,
   output logic [8:0]  pixel_y,
   output logic        pixel_last,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        busy,
   output logic        read_finished
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
   localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t             state_reg;
   logic [8:0]         x_reg, y_reg;
   logic [18:0]        bram_address_reg;
   logic               busy_reg, read_finished_reg;
   logic [CNT_W-1:0]   credit_reg, credit_next, credit_after_pop;

   // Tag pipe: stage 0 travels with the issued address, stage BRAM_LATENCY
   // lines up with the cycle in which that address's data is on bram_data.
   logic               tag_valid_reg [0:BRAM_LATENCY];
   logic [8:0]         tag_x_reg     [0:BRAM_LATENCY];
   logic [8:0]         tag_y_reg     [0:BRAM_LATENCY];
   logic               tag_last_reg  [0:BRAM_LATENCY];

   // Output FIFO: {data, x, y, last}
   logic [19:0]        fifo_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [19:0]        head_entry, push_entry;

   logic               pop, push, issue, has_credit, issue_last;
   logic [8:0]         next_x, next_y;
   logic [18:0]        next_address;

   assign pixel_valid = (count_reg != '0);
   assign pop         = pixel_valid & pixel_ready;
   assign push        = tag_valid_reg[BRAM_LATENCY];
   assign push_entry  = {bram_data, tag_x_reg[BRAM_LATENCY], tag_y_reg[BRAM_LATENCY],
                         tag_last_reg[BRAM_LATENCY]};
   assign head_entry  = fifo_mem[rd_ptr_reg];

   // Show-ahead head; gated so a freshly reset FIFO presents zeros
   assign pixel_data  = pixel_valid & head_entry[19];
   assign pixel_x     = pixel_valid ? head_entry[18:10] : 9'd0;
   assign pixel_y     = pixel_valid ? head_entry[9:1]   : 9'd0;
   assign pixel_last  = pixel_valid & head_entry[0];

   assign bram_address  = bram_address_reg;
   assign busy          = busy_reg;
   assign read_finished = read_finished_reg;

   // Next coordinate, credit test and issue decision
   always_comb begin
      next_x = 9'd0;
      next_y = 9'd0;
      if (state_reg == READ) begin
         if (x_reg == X_MAX) begin
            next_x = 9'd0;
            next_y = y_reg + 9'd1;
         end else begin
            next_x = x_reg + 9'd1;
            next_y = y_reg;
         end
      end
      next_address     = 19'(next_x) + 19'(next_y) * 19'(WIDTH);
      issue_last       = (next_x == X_MAX) && (next_y == Y_MAX);
      // Credits count FIFO entries plus reads still inside the BRAM pipe
      credit_after_pop = credit_reg - CNT_W'(pop);
      has_credit       = credit_after_pop < CNT_W'(FIFO_DEPTH);
      issue            = ((state_reg == IDLE) && start_read) ||
                         ((state_reg == READ) && has_credit);
      credit_next      = credit_after_pop + CNT_W'(issue);
   end

   // Scan FSM with address counters and registered status outputs
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_reg         <= IDLE;
         x_reg             <= 9'd0;
         y_reg             <= 9'd0;
         bram_address_reg  <= 19'd0;
         busy_reg          <= 1'b0;
         read_finished_reg <= 1'b0;
         credit_reg        <= '0;
      end else begin
         credit_reg <= credit_next;
         if (issue) begin
            x_reg            <= next_x;
            y_reg            <= next_y;
            bram_address_reg <= next_address;
         end
         case (state_reg)
            IDLE: begin
               if (start_read) begin
                  state_reg <= issue_last ? DRAIN : READ;
                  busy_reg  <= 1'b1;
               end
            end
            READ: begin
               if (issue && issue_last)
                  state_reg <= DRAIN;
            end
            DRAIN: begin
               if (pop && pixel_last) begin
                  state_reg         <= DONE;
                  read_finished_reg <= 1'b1;
               end
            end
            default: begin
               state_reg         <= IDLE;
               busy_reg          <= 1'b0;
               read_finished_reg <= 1'b0;
            end
         endcase
      end
   end

   // Tag pipe entry stage, loaded alongside each issued address
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         tag_valid_reg[0] <= 1'b0;
         tag_x_reg[0]     <= 9'd0;
         tag_y_reg[0]     <= 9'd0;
         tag_last_reg[0]  <= 1'b0;
      end else begin
         tag_valid_reg[0] <= issue;
         if (issue) begin
            tag_x_reg[0]    <= next_x;
            tag_y_reg[0]    <= next_y;
            tag_last_reg[0] <= issue_last;
         end
      end
   end

   generate
      for (genvar gi = 1; gi <= BRAM_LATENCY; gi++) begin : g_tag_pipe
         // Shift tags one stage per clock to match BRAM latency
         always_ff @(posedge clk_in) begin
            if (!rst_in) begin
               tag_valid_reg[gi] <= 1'b0;
               tag_x_reg[gi]     <= 9'd0;
               tag_y_reg[gi]     <= 9'd0;
               tag_last_reg[gi]  <= 1'b0;
            end else begin
               tag_valid_reg[gi] <= tag_valid_reg[gi-1];
               tag_x_reg[gi]     <= tag_x_reg[gi-1];
               tag_y_reg[gi]     <= tag_y_reg[gi-1];
               tag_last_reg[gi]  <= tag_last_reg[gi-1];
            end
         end
      end
   endgenerate

   // FIFO storage write; pointers decide which entries are live
   always_ff @(posedge clk_in) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= push_entry;
   end

   // FIFO pointers and occupancy; credits guarantee no overflow
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule
